mesh_drain: RTL and testbench
=============================

Name: mesh_drain

Overview:
- Sits directly downstream of the sorting mesh.
- On a one-cycle start pulse (sort complete), snapshots all N PE results of the form {valid, addr, data}.
- Streams the snapshot out one entry per accepted beat, in PE index order 0..N-1, over a valid/ready interface.
- Checks each entry against the routing invariant (valid=1, addr=index) and reports the mismatch count and the index of the first mismatch.

Parameters:
- N, 64, number of PEs / entries.
- SQRT_N, 8, mesh side; informational, with the requirement SQRT_N*SQRT_N == N.
- ADDR_WIDTH, 6, address field width; requires 2**ADDR_WIDTH >= N.
- DATA_WIDTH, 6, payload field width.
- WIDTH, ADDR_WIDTH+DATA_WIDTH; an entry is WIDTH+1 bits with valid as the MSB.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; the snapshot is taken in the same cycle.
- results_flat  in  N*(WIDTH+1)  entry k occupies bits [k*(WIDTH+1) +: WIDTH+1].
- busy  out  1  high from the snapshot until the last beat is accepted.
- out_valid  out  1  a beat is presented.
- out_ready  in  1  consumer accepts the beat.
- out_entry  out  WIDTH+1  {valid, addr, data} of the current entry.
- out_index  out  ADDR_WIDTH  PE index of the current entry.
- out_last  out  1  high with the beat for index N-1.
- out_err  out  1  the current beat violates the invariant.
- done  out  1  one-cycle pulse after the last beat is accepted.
- err_count  out  ADDR_WIDTH+1  mismatches in the last drain; saturates at N.
- first_err_idx  out  ADDR_WIDTH  index of the first mismatch; valid only when err_count != 0.

Behaviour:
- Reset (async, rst_n=0) forces:
  - all outputs to 0;
  - FSM to IDLE;
  - index counter to 0;
  - snapshot register contents are don't-care.
- FSM states:
  - IDLE:
    - start=1 → snapshot results_flat, clear err_count and first_err_idx, set index=0, go to DRAIN.
    - start=0 → stay in IDLE.
  - DRAIN:
    - out_valid=1.
    - out_entry = snapshot[index]; out_index = index; out_last = (index==N-1).
    - out_err = ~entry.valid | (entry.addr != index).
    - A beat transfers on out_valid & out_ready. On transfer:
      - if out_err, increment err_count (saturating at N);
      - if out_err and err_count was 0, load first_err_idx=index;
      - if index==N-1, go to DONE; otherwise index+1.
    - Without out_ready, all out_* signals hold stable (standard valid/ready: valid never drops before acceptance).
  - DONE: done=1 for exactly one cycle, then IDLE. err_count and first_err_idx hold until the next start.
- busy = (state != IDLE).
- Latency:
  - first beat is presented the cycle after start;
  - with out_ready held at 1, N beats take N consecutive cycles;
  - done asserts the cycle after the last transfer.
- Boundary conditions:
  - start while busy is ignored; the snapshot is not overwritten.
  - start in the DONE cycle is ignored; start is honoured only in IDLE.
  - results_flat changing after the snapshot has no effect on the output stream.
  - Index wrap: the counter never exceeds N-1; the transition to DONE replaces the increment.
  - rst_n asserted mid-drain aborts immediately:
    - no done pulse;
    - counters return to 0.
  - The data field is not checked; the drain is routing-agnostic about payload.

Decomposition:
- Package mesh_pkg holds:
  - entry field offsets: VALID_BIT=WIDTH, ADDR_LSB=DATA_WIDTH;
  - the FSM state encoding (IDLE, DRAIN, DONE);
  - a function extracting entry k from the flat bus.
- The module is natural as a single unit, with no sub-module.
- The snapshot is a register array indexed by the counter, not a flattened mux tree in user code.

Test Plan:
- Sorted input (entry k = {1, k, 63-k}), start pulse, out_ready=1:
  - 64 beats on consecutive cycles;
  - out_index 0..63, out_entry[k]={1,k,63-k};
  - out_last only on k=63;
  - done 1 cycle after beat 63;
  - err_count=0.
- Same input, out_ready toggling 1,0,1,0:
  - out_* stable through stalls;
  - exactly 64 transfers;
  - done after the 64th transfer.
- Entries 5 and 40 with addr swapped (addr=40 at k=5, addr=5 at k=40):
  - out_err on beats 5 and 40 only;
  - err_count=2, first_err_idx=5.
- All entries valid=0 → err_count saturates at 64; first_err_idx=0.
- Second start pulse at beat 10, plus results_flat changed mid-drain:
  - stream unchanged;
  - beats 10..63 still come from the original snapshot.
- rst_n low at beat 20, then release:
  - outputs immediately 0, no done, busy=0;
  - a new start drains from index 0 with fresh counters.

Source files
------------

// File: rtl/mesh_pkg.sv
// Shared definitions for the sorting-mesh drain: entry layout, FSM encoding
// and the flat-bus entry accessor.
package mesh_pkg;

  localparam int MESH_N      = 64;
  localparam int MESH_SQRT_N = 8;
  localparam int MESH_ADDR_W = 6;
  localparam int MESH_DATA_W = 6;
  localparam int MESH_WIDTH  = MESH_ADDR_W + MESH_DATA_W;
  localparam int ENTRY_W     = MESH_WIDTH + 1;
  localparam int FLAT_W      = MESH_N * ENTRY_W;

  localparam int VALID_BIT = MESH_WIDTH;
  localparam int ADDR_LSB  = MESH_DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic                   valid;
    logic [MESH_ADDR_W-1:0] addr;
    logic [MESH_DATA_W-1:0] data;
  } entry_t;

  function automatic entry_t entry_at(input logic [FLAT_W-1:0] flat, input int k);
    return entry_t'(flat[k*ENTRY_W +: ENTRY_W]);
  endfunction

endpackage

// File: rtl/mesh_drain.sv
// Snapshots the mesh PE results on start and streams them out in index order
// over valid/ready, flagging entries that break the valid=1, addr=index invariant.
module mesh_drain
  import mesh_pkg::*;
#(
  parameter int N          = MESH_N,
  parameter int SQRT_N     = MESH_SQRT_N,
  parameter int ADDR_WIDTH = MESH_ADDR_W,
  parameter int DATA_WIDTH = MESH_DATA_W,
  parameter int WIDTH      = ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N*(WIDTH+1)-1:0]   results_flat,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH:0]           out_entry,
  output logic [ADDR_WIDTH-1:0]    out_index,
  output logic                     out_last,
  output logic                     out_err,
  output logic                     done,
  output logic [ADDR_WIDTH:0]      err_count,
  output logic [ADDR_WIDTH-1:0]    first_err_idx
);

  // The entry layout and accessor live in the package, so overrides must match it.
  if (SQRT_N * SQRT_N != N || (2 ** ADDR_WIDTH) < N || N != MESH_N ||
      ADDR_WIDTH != MESH_ADDR_W || DATA_WIDTH != MESH_DATA_W) begin : g_param_check
    $error("mesh_drain: parameters inconsistent with mesh_pkg entry layout");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH:0]   ERR_MAX  = (ADDR_WIDTH + 1)'(N);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [ADDR_WIDTH:0]     err_count_q;
  logic [ADDR_WIDTH-1:0]   first_err_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    done_q;
  entry_t                  snap_q [N];

  entry_t                  cur;
  logic                    beat_err;
  logic                    last_beat;
  logic [ADDR_WIDTH:0]     err_count_d;

  // NOTE: the snapshot array has no reset; it is only read after a start has loaded it.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      for (int k = 0; k < N; k++) begin
        snap_q[k] <= entry_at(results_flat, k);
      end
    end
  end

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    cur         = snap_q[idx_q];
    beat_err    = valid_q && (!cur.valid || (cur.addr != idx_q));
    last_beat   = valid_q && (idx_q == LAST_IDX);
    err_count_d = (err_count_q == ERR_MAX) ? err_count_q : err_count_q + 1'b1;
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      err_count_q <= '0;
      first_err_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= DRAIN;
            idx_q       <= '0;
            err_count_q <= '0;
            first_err_q <= '0;
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (beat_err) begin
              err_count_q <= err_count_d;
              if (err_count_q == '0) first_err_q <= idx_q;
            end
            // Leaving for DONE replaces the increment, so the index never passes N-1.
            if (last_beat) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          idx_q   <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign out_valid     = valid_q;
  assign out_entry     = valid_q ? cur : '0;
  assign out_index     = idx_q;
  assign out_last      = last_beat;
  assign out_err       = beat_err;
  assign done          = done_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_q;

endmodule

// File: tb/tb_mesh_drain.sv
// Self-checking bench for mesh_drain: table of drain scenarios, a per-beat
// scoreboard filled at start time, and hand sequences for restart/reset corners.
module tb_mesh_drain;
  import mesh_pkg::*;

  localparam int NE = MESH_N;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [FLAT_W-1:0] results_flat;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [ENTRY_W-1:0] out_entry;
  logic [5:0]        out_index;
  logic              out_last;
  logic              out_err;
  logic              done;
  logic [6:0]        err_count;
  logic [5:0]        first_err_idx;

  mesh_drain dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .results_flat (results_flat),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_entry    (out_entry),
    .out_index    (out_index),
    .out_last     (out_last),
    .out_err      (out_err),
    .done         (done),
    .err_count    (err_count),
    .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ENTRY_W-1:0] entry;
    logic [5:0]         idx;
    logic               last;
    logic               err;
  } beat_t;

  // pattern: 0 sorted, 1 swap 5/40, 2 all invalid, 3 random data, 4 bad addr at 63
  // mode: 0 ready held, 1 ready toggling; action: 0 none, 1 restart+scramble at
  // beat 10, 2 reset at beat 20, 3 start held in the DONE cycle
  typedef struct {
    int pattern;
    int mode;
    int action;
    int exp_err;
    int exp_first;
  } tvec_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    n_xfer   = 0;
  int    first_xfer_cyc = -1;
  int    last_xfer_cyc  = -1;

  logic              prev_valid = 1'b0;
  logic              prev_ready = 1'b0;
  logic [21:0]       prev_out   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FLAT_W-1:0] make_pattern(input int p);
    logic [FLAT_W-1:0] r;
    logic       v;
    logic [5:0] a;
    logic [5:0] d;
    r = '0;
    for (int k = 0; k < NE; k++) begin
      v = 1'b1;
      a = 6'(k);
      d = 6'(63 - k);
      case (p)
        1: begin
          if (k == 5)  a = 6'd40;
          if (k == 40) a = 6'd5;
        end
        2: v = 1'b0;
        3: d = 6'($urandom_range(0, 63));
        4: if (k == 63) a = 6'd0;
        default: ;
      endcase
      r[k*ENTRY_W +: ENTRY_W] = {v, a, d};
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: samples at the falling edge, away from the active edge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready)
        check("stall_hold", 32'({out_valid, out_entry, out_index, out_last, out_err}),
              32'({1'b1, prev_out[20:0]}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: index %0d with empty scoreboard", out_index);
        end else begin
          e = exp_q.pop_front();
          check("beat_entry", 32'(out_entry), 32'(e.entry));
          check("beat_index", 32'(out_index), 32'(e.idx));
          check("beat_last",  32'(out_last),  32'(e.last));
          check("beat_err",   32'(out_err),   32'(e.err));
        end
        if (n_xfer == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        n_xfer++;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_out   = {out_valid, out_entry, out_index, out_last, out_err};
    end
  end

  task automatic run_drain(input tvec_t v);
    logic [FLAT_W-1:0] pat;
    logic [ENTRY_W-1:0] ent;
    beat_t b;
    int  start_cyc;
    bit  act_done;
    bit  done_seen;
    pat = make_pattern(v.pattern);
    act_done  = 1'b0;
    done_seen = 1'b0;

    @(posedge clk); #1;
    results_flat = pat;
    for (int k = 0; k < NE; k++) begin
      ent     = pat[k*ENTRY_W +: ENTRY_W];
      b.entry = ent;
      b.idx   = 6'(k);
      b.last  = (k == NE - 1);
      b.err   = !ent[VALID_BIT] || (ent[ADDR_LSB +: 6] != 6'(k));
      exp_q.push_back(b);
    end
    n_xfer         = 0;
    first_xfer_cyc = -1;
    last_xfer_cyc  = -1;
    start     = 1'b1;
    out_ready = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared_on_start", 32'(err_count), 32'd0);

    for (int i = 0; i < 400; i++) begin
      start     = 1'b0;
      out_ready = (v.mode == 0) || (i % 2 == 0);
      if (v.action == 1 && n_xfer == 10 && !act_done) begin
        start        = 1'b1;
        results_flat = ~pat;
        act_done     = 1'b1;
      end
      if (v.action == 2 && n_xfer == 20) begin
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_entry", 32'(out_entry), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_first_err", 32'(first_err_idx), 32'd0);
        repeat (2) begin
          @(posedge clk); #1;
          check("rst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        exp_q.delete();
        return;
      end
      @(posedge clk); #1;
      if (done) begin
        done_seen = 1'b1;
        break;
      end
    end

    if (!done_seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done after %0d transfers", n_xfer);
      return;
    end
    check("xfer_count",   32'(n_xfer), 32'd64);
    check("sb_drained",   32'(exp_q.size()), 32'd0);
    check("done_latency", 32'(cyc), 32'(last_xfer_cyc + 1));
    check("err_count",    32'(err_count), 32'(v.exp_err));
    if (v.exp_err != 0) check("first_err_idx", 32'(first_err_idx), 32'(v.exp_first));
    check("valid_low_in_done", 32'(out_valid), 32'd0);
    if (v.mode == 0) begin
      check("first_beat_latency", 32'(first_xfer_cyc), 32'(start_cyc));
      check("consecutive_beats",  32'(last_xfer_cyc - first_xfer_cyc), 32'd63);
    end
    if (v.action == 3) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    if (v.action == 3) begin
      @(posedge clk); #1;
      check("start_in_done_ignored", 32'(busy), 32'd0);
      check("no_beat_after_done", 32'(out_valid), 32'd0);
    end
    check("err_count_holds", 32'(err_count), 32'(v.exp_err));
  endtask

  tvec_t vecs [9];

  initial begin
    vecs[0] = '{pattern: 0, mode: 0, action: 0, exp_err: 0,  exp_first: 0};
    vecs[1] = '{pattern: 0, mode: 1, action: 0, exp_err: 0,  exp_first: 0};
    vecs[2] = '{pattern: 1, mode: 0, action: 0, exp_err: 2,  exp_first: 5};
    vecs[3] = '{pattern: 2, mode: 0, action: 0, exp_err: 64, exp_first: 0};
    vecs[4] = '{pattern: 3, mode: 1, action: 0, exp_err: 0,  exp_first: 0};
    vecs[5] = '{pattern: 4, mode: 0, action: 0, exp_err: 1,  exp_first: 63};
    vecs[6] = '{pattern: 0, mode: 0, action: 1, exp_err: 0,  exp_first: 0};
    vecs[7] = '{pattern: 1, mode: 0, action: 2, exp_err: 0,  exp_first: 0};
    vecs[8] = '{pattern: 1, mode: 1, action: 3, exp_err: 2,  exp_first: 5};

    rst_n        = 1'b0;
    start        = 1'b0;
    out_ready    = 1'b0;
    results_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_done",      32'(done),      32'd0);
    check("reset_out_index", 32'(out_index), 32'd0);
    check("reset_out_entry", 32'(out_entry), 32'd0);
    check("reset_out_last",  32'(out_last),  32'd0);
    check("reset_out_err",   32'(out_err),   32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_first_err", 32'(first_err_idx), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start", 32'(busy), 32'd0);

    for (int t = 0; t < 9; t++) begin
      run_drain(vecs[t]);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
